// File: rtl/i2c_cmd_pkg.sv
// i2c_cmd_pkg
//  Shared definitions for the I2C command engine:
//   - 3-bit command codes, matching the instruction decoder's I2C field
//   - FSM state encoding
//   - quarter-phase indices within one SCL period
package i2c_cmd_pkg;

    localparam logic [2:0] I2C_NOP     = 3'b000;
    localparam logic [2:0] I2C_START   = 3'b001;
    localparam logic [2:0] I2C_STOP    = 3'b010;
    localparam logic [2:0] I2C_SENDCON = 3'b011;
    localparam logic [2:0] I2C_SENDI2C = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RSTART,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_DONE
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick
//  Quarter-SCL-period prescaler. Counts while enabled, restarts at 0 on a
//  synchronous clear, and pulses o_tick for one cycle every CLK_DIV cycles.
//  The first tick after a clear comes CLK_DIV cycles later.
// Ports
//  i_clk    core clock
//  i_rst_n  asynchronous active-low reset
//  i_en     count enable (engine busy)
//  i_clr    synchronous restart (command accept)
//  o_tick   one-cycle quarter tick
module i2c_quarter_tick #(
    parameter int CLK_DIV = 68
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign o_tick = i_en && !i_clr && (cnt == LAST);

endmodule

// File: rtl/i2c_cmd_engine.sv
// i2c_cmd_engine
//  Executes decoder I2C commands (START, STOP, SENDCON, SENDI2C) as
//  open-drain SCL/SDA sequences toward an SSD1306 and samples the slave ACK.
//  The core stalls on o_busy; o_done pulses once per completed command.
// Configuration
//  I2C_CMD_ENGINE_ACK_CHECK_EN : when defined, i_sda is sampled in the ACK
//  slot and a NACK sets the sticky o_ack_err. When undefined, the ACK slot is
//  still clocked with SDA released but o_ack_err stays 0.
// Ports
//  i_clk, i_rst_n  clock, asynchronous active-low reset
//  i_i2c_ctrl      command (000 NOP, 001 START, 010 STOP, 011 SENDCON,
//                  100 SENDI2C, others NOP)
//  i_data          byte for SENDI2C, latched on accept
//  i_sda           SDA pad input
//  o_scl_oe        1 pulls SCL low
//  o_sda_oe        1 pulls SDA low
//  o_busy          command in progress
//  o_done          one-cycle completion pulse
//  o_ack_err       sticky NACK flag, cleared by START
module i2c_cmd_engine
    import i2c_cmd_pkg::*;
#(
    parameter int         CLK_DIV    = 68,
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_i2c_ctrl,
    input  logic [7:0] i_data,
    input  logic       i_sda,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err
);

`ifdef I2C_CMD_ENGINE_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    state_t      state;
    logic [1:0]  q;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        bus_active;
    logic        tick;
    logic        accept;

    // o_done blocks acceptance so a command held across completion runs once.
    assign accept = !o_busy && !o_done &&
                    (i_i2c_ctrl >= I2C_START) && (i_i2c_ctrl <= I2C_SENDI2C);

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (o_busy),
        .i_clr   (accept),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            q          <= Q0;
            bit_cnt    <= 3'd7;
            shreg      <= 8'h00;
            bus_active <= 1'b0;
            o_scl_oe   <= 1'b0;
            o_sda_oe   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ack_err  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (tick) begin
                q <= q + 2'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        o_busy  <= 1'b1;
                        q       <= Q0;
                        bit_cnt <= 3'd7;
                        case (i_i2c_ctrl)
                            I2C_START: begin
                                o_ack_err <= 1'b0;
                                state     <= bus_active ? ST_RSTART : ST_START;
                            end
                            I2C_STOP: begin
                                state <= bus_active ? ST_STOP : ST_DONE;
                            end
                            I2C_SENDCON: begin
                                shreg <= {SLAVE_ADDR, 1'b0};
                                state <= bus_active ? ST_BIT : ST_DONE;
                            end
                            default: begin
                                shreg <= i_data;
                                state <= bus_active ? ST_BIT : ST_DONE;
                            end
                        endcase
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (q == Q0) begin
                            o_sda_oe <= 1'b1;
                        end else begin
                            o_scl_oe   <= 1'b1;
                            bus_active <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_RSTART: begin
                    if (tick) begin
                        case (q)
                            Q0: o_sda_oe <= 1'b0;
                            Q1: o_scl_oe <= 1'b0;
                            Q2: o_sda_oe <= 1'b1;
                            default: begin
                                o_scl_oe <= 1'b1;
                                state    <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_BIT: begin
                    if (tick) begin
                        case (q)
                            Q0: o_sda_oe <= ~shreg[7];
                            Q1: o_scl_oe <= 1'b0;
                            Q2: ;
                            default: begin
                                o_scl_oe <= 1'b1;
                                shreg    <= {shreg[6:0], 1'b0};
                                bit_cnt  <= bit_cnt - 3'd1;
                                // Counter wraps 0 -> 7 as the ninth (ACK) slot begins.
                                if (bit_cnt == 3'd0) begin
                                    state <= ST_ACK;
                                end
                            end
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick) begin
                        case (q)
                            Q0: o_sda_oe <= 1'b0;
                            Q1: o_scl_oe <= 1'b0;
                            Q2: begin
                                if (ACK_CHECK && i_sda) begin
                                    o_ack_err <= 1'b1;
                                end
                            end
                            default: begin
                                o_scl_oe <= 1'b1;
                                state    <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        case (q)
                            Q0: o_sda_oe <= 1'b1;
                            Q1: o_scl_oe <= 1'b0;
                            default: begin
                                o_sda_oe   <= 1'b0;
                                bus_active <= 1'b0;
                                state      <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_engine.sv
// tb_i2c_cmd_engine
//  Table of hand-specified commands plus random command sequences, checked
//  cycle by cycle against a line-level model of each command's quarter steps.
module tb_i2c_cmd_engine;
    import i2c_cmd_pkg::*;

    localparam int CLK_DIV = 4;

`ifdef I2C_CMD_ENGINE_ACK_CHECK_EN
    localparam bit ACKCHK = 1'b1;
`else
    localparam bit ACKCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ctrl = I2C_NOP;
    logic [7:0] data = 8'h00;
    logic       slave_pull = 1'b0;
    logic       i_sda;
    logic       scl_oe, sda_oe, busy, done, ack_err;

    int checks = 0;
    int failures = 0;

    // model state
    bit m_bus = 0, m_scl = 0, m_sda = 0, m_err = 0;

    always #5 clk = ~clk;

    // open-drain SDA: master or slave pulling gives 0
    assign i_sda = ~(sda_oe | slave_pull);

    i2c_cmd_engine #(
        .CLK_DIV    (CLK_DIV),
        .SLAVE_ADDR (7'h3C)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_i2c_ctrl (ctrl),
        .i_data     (data),
        .i_sda      (i_sda),
        .o_scl_oe   (scl_oe),
        .o_sda_oe   (sda_oe),
        .o_busy     (busy),
        .o_done     (done),
        .o_ack_err  (ack_err)
    );

    typedef struct {
        logic [2:0] cmd;
        logic [7:0] d;
        bit         nack;
        bit         hold;
        int         exp_ticks;
        int         exp_err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Run one accepted command and compare every cycle with the model.
    // ops codes per tick: 0 none, 1 SDA low, 2 SDA release, 3 SCL low, 4 SCL release
    task automatic exec_cmd(input logic [2:0] cmd, input logic [7:0] d, input bit nack,
                            input bit hold, input int exp_ticks, input int exp_err,
                            input bit use_exp);
        int   ops[$];
        bit   escl[0:40];
        bit   esda[0:40];
        int   n, k, done_at, bad_c, act_v, exp_v;
        bit   is_send, bus0, pend_err;
        logic [7:0] byte_v;
        logic [8:0] samp;
        int   ns;
        bit   prev_scl;

        bus0     = m_bus;
        is_send  = (cmd == I2C_SENDCON) || (cmd == I2C_SENDI2C);
        byte_v   = (cmd == I2C_SENDCON) ? 8'h78 : d;
        pend_err = m_err;
        if (cmd == I2C_START) begin
            pend_err = 0;
            if (m_bus) ops = '{2, 4, 1, 3};
            else       ops = '{1, 3};
        end else if (cmd == I2C_STOP && m_bus) begin
            ops = '{1, 4, 2};
        end else if (is_send && m_bus) begin
            for (int i = 7; i >= 0; i--) begin
                ops.push_back(byte_v[i] ? 2 : 1);
                ops.push_back(4);
                ops.push_back(0);
                ops.push_back(3);
            end
            ops.push_back(2); ops.push_back(4); ops.push_back(0); ops.push_back(3);
            if (nack && ACKCHK) pend_err = 1;
        end
        n = ops.size();
        escl[0] = m_scl;
        esda[0] = m_sda;
        for (int t = 1; t <= n; t++) begin
            escl[t] = escl[t-1];
            esda[t] = esda[t-1];
            case (ops[t-1])
                1: esda[t] = 1;
                2: esda[t] = 0;
                3: escl[t] = 1;
                4: escl[t] = 0;
                default: ;
            endcase
        end

        @(negedge clk);
        ctrl = cmd;
        data = d;
        @(posedge clk); #1;
        data = 8'($urandom);
        if (!hold) ctrl = I2C_NOP;

        done_at = -1; bad_c = -1; act_v = 0; exp_v = 0;
        samp = '0; ns = 0; prev_scl = m_scl;
        for (int c = 0; c <= 4*n + 2; c++) begin
            slave_pull = is_send && bus0 && !nack && (c >= 133) && (c <= 143);
            k = c / 4;
            if (k > n) k = n;
            if (bad_c < 0 || c == 4*n + 2) begin
                if (bad_c < 0) begin
                    act_v = {scl_oe, sda_oe, busy, done};
                    exp_v = {escl[k], esda[k], (c <= 4*n), (c == 4*n + 1)};
                    if (act_v != exp_v) bad_c = c;
                end
            end
            if (done && done_at < 0) done_at = c;
            if (is_send && bus0 && prev_scl && !scl_oe && ns < 9) begin
                samp[8-ns] = i_sda;
                ns++;
            end
            prev_scl = scl_oe;
            if (c < 4*n + 2) begin
                @(posedge clk); #1;
            end
        end
        ctrl = I2C_NOP;
        slave_pull = 0;

        chk($sformatf("trace cmd%0d c%0d {scl,sda,busy,done}", cmd, bad_c), act_v, exp_v);
        chk($sformatf("done_cycle cmd%0d", cmd), done_at, 4*n + 1);
        chk($sformatf("ack_err cmd%0d", cmd), ack_err, pend_err);
        if (use_exp) begin
            chk($sformatf("tbl_done_cycle cmd%0d", cmd), done_at, 4*exp_ticks + 1);
            chk($sformatf("tbl_ack_err cmd%0d", cmd), ack_err, exp_err & ACKCHK);
        end
        if (is_send && bus0)
            chk($sformatf("bus_byte cmd%0d", cmd), samp, {byte_v, nack});

        m_scl = escl[n];
        m_sda = esda[n];
        m_err = pend_err;
        if (cmd == I2C_START) m_bus = 1;
        if (cmd == I2C_STOP)  m_bus = 0;
    endtask

    // Illegal/NOP codes must not start anything.
    task automatic nop_cmd(input logic [2:0] cmd);
        int bad;
        bad = 0;
        @(negedge clk);
        ctrl = cmd;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (busy || done || scl_oe != m_scl || sda_oe != m_sda) bad++;
        end
        ctrl = I2C_NOP;
        chk($sformatf("nop_idle cmd%0d", cmd), bad, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [2:0] r;

        tbl[0]  = '{I2C_START,   8'h00, 0, 0,  2, 0};
        tbl[1]  = '{I2C_SENDCON, 8'h00, 0, 0, 36, 0};
        tbl[2]  = '{I2C_SENDI2C, 8'hA5, 1, 0, 36, 1};
        tbl[3]  = '{I2C_START,   8'h00, 0, 0,  4, 0};
        tbl[4]  = '{I2C_STOP,    8'h00, 0, 0,  3, 0};
        tbl[5]  = '{I2C_STOP,    8'h00, 0, 0,  0, 0};
        tbl[6]  = '{I2C_SENDI2C, 8'h55, 0, 0,  0, 0};
        tbl[7]  = '{I2C_START,   8'h00, 0, 1,  2, 0};
        tbl[8]  = '{I2C_SENDI2C, 8'h00, 1, 0, 36, 1};
        tbl[9]  = '{I2C_SENDI2C, 8'hFF, 0, 0, 36, 1};
        tbl[10] = '{I2C_STOP,    8'h00, 0, 0,  3, 1};
        tbl[11] = '{I2C_START,   8'h00, 0, 0,  2, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {scl_oe, sda_oe, busy, done, ack_err}, 0);
        @(negedge clk);
        rst_n = 1;

        // idle for 100 cycles
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (scl_oe || sda_oe || busy || done) bad++;
        end
        chk("idle_100", bad, 0);

        for (int i = 0; i < 12; i++)
            exec_cmd(tbl[i].cmd, tbl[i].d, tbl[i].nack, tbl[i].hold,
                     tbl[i].exp_ticks, tbl[i].exp_err, 1);

        // reset in the middle of a byte (bit 3 slot)
        @(negedge clk);
        ctrl = I2C_SENDI2C;
        data = 8'h96;
        @(posedge clk); #1;
        ctrl = I2C_NOP;
        repeat (70) @(posedge clk);
        #1;
        chk("mid_busy_before_reset", busy, 1);
        #1;
        rst_n = 0;
        #1;
        chk("mid_reset_lines_busy", {scl_oe, sda_oe, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_bus = 0; m_scl = 0; m_sda = 0; m_err = 0;
        exec_cmd(I2C_START, 8'h00, 0, 0, 2, 0, 1);
        exec_cmd(I2C_SENDCON, 8'h00, 0, 0, 36, 0, 1);

        // random command stream
        for (int i = 0; i < 25; i++) begin
            r = 3'($urandom_range(0, 7));
            if (r == I2C_NOP || r > I2C_SENDI2C)
                nop_cmd(r);
            else
                exec_cmd(r, 8'($urandom), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 3) == 0), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
